// File: rtl/escritor_imagen_if.sv
// escritor_imagen_if: pixel-stream handshake plus frame-buffer write port of the image writer.
interface escritor_imagen_if;
  logic start, valid, ready, we, done, error;
  logic [7:0] Pixel_in, Dato;
  logic [15:0] Address;
  modport master(output start, Pixel_in, valid, input ready, we, Address, Dato, done, error);
  modport slave(input start, Pixel_in, valid, output ready, we, Address, Dato, done, error);
endinterface

// File: rtl/escritor_imagen.sv
// escritor_imagen: turns a valid/ready pixel stream into row-major {row,col} frame-buffer writes.
module escritor_imagen #(
  parameter int ANCHO = 256,
  parameter int ALTO = 256
) (
  input logic clk,
  input logic reset,
  escritor_imagen_if.slave bus
);
  localparam logic [7:0] COL_MAX = 8'(ANCHO - 1);
  localparam logic [7:0] ROW_MAX = 8'(ALTO - 1);
  typedef enum logic [1:0] {IDLE, CARGA, FIN} state_t;
  state_t state, state_n;
  logic [7:0] col, row, col_n, row_n;
  logic xfer, last;
  // a start colliding with a pixel restarts the frame and drops that pixel
  always_comb begin
    xfer = state == CARGA && bus.valid && !bus.start;
    last = row == ROW_MAX && col == COL_MAX;
    state_n = bus.start ? CARGA : state == FIN ? IDLE : xfer && last ? FIN : state;
    col_n = bus.start ? '0 : !xfer ? col : col == COL_MAX ? '0 : col + 8'd1;
    row_n = bus.start ? '0 : xfer && col == COL_MAX && !last ? row + 8'd1 : row;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      bus.we <= 1'b0;
      bus.Address <= '0;
      bus.Dato <= '0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      state <= state_n;
      col <= col_n;
      row <= row_n;
      bus.we <= xfer;
      if (xfer) begin
        bus.Address <= {row, col};
        bus.Dato <= bus.Pixel_in;
      end
      bus.done <= xfer && last;
      bus.error <= bus.start && state == CARGA;
    end
  end
  assign bus.ready = state == CARGA;
endmodule

// File: tb/tb_escritor_imagen.sv
// tb_escritor_imagen: randomized scoreboard bench on a 4x2 frame plus a full 256x256 frame run.
module tb_escritor_imagen;
  localparam int A = 4;
  localparam int H = 2;
  typedef struct {
    logic we;
    logic [15:0] addr;
    logic [7:0] data;
    logic done;
    logic error;
  } ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  escritor_imagen_if bus();
  escritor_imagen_if big();
  escritor_imagen #(.ANCHO(A), .ALTO(H)) dut (.clk(clk), .reset(reset), .bus(bus));
  escritor_imagen dut_big (.clk(clk), .reset(reset), .bus(big));
  ev_t exp_q[$];
  ev_t e;
  int checks = 0, errors = 0;
  bit busy = 1'b0;
  int n = 0;
  int big_n = 0, big_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // model: a frame is a flat pixel count n; the address is that count split into row and column
  task automatic cycle(input logic st, input logic v, input logic [7:0] px);
    check("ready", 32'(bus.ready), 32'(busy));
    bus.start = st;
    bus.valid = v;
    bus.Pixel_in = px;
    if (st) begin
      if (busy) exp_q.push_back('{we: 1'b0, addr: 16'h0, data: 8'h0, done: 1'b0, error: 1'b1});
      busy = 1'b1;
      n = 0;
    end else if (busy && v) begin
      exp_q.push_back('{we: 1'b1, addr: {8'(n / A), 8'(n % A)}, data: px, done: n == A * H - 1, error: 1'b0});
      n++;
      if (n == A * H) busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input logic v);
    reset = 1'b1;
    bus.start = 1'b0;
    bus.valid = v;
    bus.Pixel_in = 8'h55;
    @(negedge clk);
    check("reset_flags", 32'({bus.ready, bus.we, bus.done, bus.error}), 32'h0);
    check("reset_addr_data", 32'({bus.Address, bus.Dato}), 32'h0);
    reset = 1'b0;
    busy = 1'b0;
    n = 0;
  endtask

  task automatic frame(input logic [7:0] base, input int gap);
    cycle(1'b1, 1'b0, 8'h0);
    for (int i = 0; i < A * H * (gap + 1); i++)
      cycle(1'b0, i % (gap + 1) == 0, base + 8'(i / (gap + 1)));
    repeat (3) cycle(1'b0, 1'b0, 8'h0);
  endtask

  always @(negedge clk) begin
    if (bus.we || bus.done || bus.error) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'({bus.we, bus.done, bus.error}), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("we_done_error", 32'({bus.we, bus.done, bus.error}), 32'({e.we, e.done, e.error}));
        if (e.we) check("addr_data", 32'({bus.Address, bus.Dato}), 32'({e.addr, e.data}));
      end
    end
  end

  always @(negedge clk) begin
    if (big.we) begin
      check("big_addr", 32'(big.Address), 32'(big_n[15:0]));
      check("big_data", 32'(big.Dato), 32'(big_n[7:0]));
      if (big.done) begin
        big_done++;
        check("big_done_pos", 32'(big_n), 32'd65535);
      end
      big_n++;
    end
  end

  initial begin
    big.start = 1'b0;
    big.valid = 1'b0;
    big.Pixel_in = 8'h0;
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 8'hAA);
      check("idle_we_addr", 32'({bus.we, bus.Address}), 32'h0);
    end
    frame(8'h10, 0);
    frame(8'h20, 1);
    cycle(1'b1, 1'b0, 8'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'h30 + 8'(i));
    cycle(1'b1, 1'b1, 8'hEE);
    for (int i = 0; i < A * H; i++) cycle(1'b0, 1'b1, 8'h40 + 8'(i));
    repeat (2) cycle(1'b0, 1'b0, 8'h0);
    cycle(1'b1, 1'b0, 8'h0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'h50 + 8'(i));
    do_reset(1'b1);
    frame(8'h60, 0);
    for (int k = 0; k < 800; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) do_reset(r[0]);
      else cycle(r < 8, $urandom_range(0, 2) != 0, 8'($urandom));
    end
    repeat (3) cycle(1'b0, 1'b0, 8'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    big.start = 1'b1;
    @(negedge clk);
    big.start = 1'b0;
    big.valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      big.Pixel_in = 8'(i);
      @(negedge clk);
    end
    big.valid = 1'b0;
    repeat (3) @(negedge clk);
    check("big_count", 32'(big_n), 32'd65536);
    check("big_done_count", 32'(big_done), 32'd1);
    check("big_ready_after", 32'(big.ready), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/escritor_imagen.md
# escritor_imagen

Image-memory writer: accepts a pixel stream over a valid/ready handshake and generates the write address, data and write-enable for the frame-buffer RAM. It is the write-side counterpart of the VGA row/column address generator. It stores pixels with the same row-major `{row, column}` addressing that the display side reads, so the image RAM can be reloaded at run time instead of being a fixed ROM. It sits between the pixel source (UART/byte loader) and the write port of the dual-port image RAM.

## Interface
- `ANCHO`, default 256: stored image width in pixels; 2..256.
- `ALTO`, default 256: stored image height in rows; 1..256.
- `clk`  in  1  Single system clock; all logic on its rising edge.
- `reset`  in  1  Reset; synchronous, active-high.
- `start`  in  1  Single-cycle pulse that begins loading a frame at pixel (0,0).
- `Pixel_in`  in  8  Pixel data (RGB332), qualified by `valid`.
- `valid`  in  1  Source has a pixel on `Pixel_in`.
- `ready`  out  1  Writer accepts a pixel this cycle. A transfer occurs when `valid & ready`.
- `we`  out  1  RAM write enable; one cycle per accepted pixel.
- `Address`  out  16  RAM write address, `{row[7:0], col[7:0]}`.
- `Dato`  out  8  RAM write data.
- `done`  out  1  One-cycle pulse; the last pixel of the frame has been written.
- `error`  out  1  One-cycle pulse; the frame was aborted by a new `start`.

## Operation
- Internal counters: `col` (8 bit, 0..ANCHO-1) and `row` (8 bit, 0..ALTO-1).
- Address is a bit concatenation, not `row*ANCHO+col`. When ANCHO<256, RAM entries with col ≥ ANCHO are never written.
- State machine has three states: IDLE, CARGA, FIN.
  - IDLE: `ready`=0. `valid` is ignored; no pixels are consumed. `start` → CARGA, with col=0 and row=0.
  - CARGA: `ready`=1.
    - On a transfer: capture `Pixel_in` and the current `{row,col}`.
    - If col=ANCHO-1: col←0 and row←row+1. Otherwise col←col+1.
    - The transfer at row=ALTO-1, col=ANCHO-1 → FIN, with `ready`=0 from the next cycle.
    - Gaps in `valid` simply hold the counters.
  - FIN: lasts exactly one cycle, then → IDLE.
- `start` while in CARGA: counters reset to 0 and the state stays CARGA. `error` pulses in the next cycle. A transfer in that same cycle is discarded: no `we`, and no counter advance from it.
- `start` while in FIN behaves as in IDLE: next state is CARGA with counters zeroed. `done` still pulses.
- Counters never wrap past the frame; the row increment at the last pixel is not performed.
- Reset at any time, including mid-frame, leads to IDLE with counters 0. A pending write is cancelled: `we` is 0 in the cycle after reset.

## Timing
- Reset values: `ready`=0, `we`=0, `Address`=0, `Dato`=0, `done`=0, `error`=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
  - The state enters CARGA at the edge where `start` is sampled. `ready`=1 from the next cycle.
- Write latency is 1: a transfer at edge t drives `we`=1 together with its `Address`/`Dato` during cycle t+1. The RAM captures the write at edge t+1.
- Throughput is one pixel per clock; back-to-back transfers produce back-to-back `we` cycles.
- `Address` and `Dato` hold their last values when `we`=0.
- `done` is asserted during the same cycle as the final `we`, which is the cycle in FIN.
- `error` is asserted in the cycle after the aborting `start` is sampled. `we` is 0 in that cycle.

## Test plan
- Full frame (ANCHO=4, ALTO=2): `start`, then 8 consecutive pixels 0x10..0x17 with `valid`=1.
  - Expect `we` for 8 cycles, with addresses 0x0000–0x0003 then 0x0100–0x0103 and data 0x10..0x17.
  - `done`=1 in the cycle of the last `we`; `ready`=0 afterwards.
- Gapped source (ANCHO=4, ALTO=2): `valid` toggling every other cycle.
  - Same 8 address/data pairs, with `we` only in the cycle after each transfer.
  - Counters hold during gaps; a single `done`.
- Idle guard: `valid`=1 with 0xAA for 10 cycles before any `start`.
  - Expect `ready`=0, no `we`, `Address` stays 0.
- Abort: `start`, 3 pixels, then `start` together with `valid`.
  - Expect `error` pulse and no `we` for the colliding pixel.
  - The next pixel is written to 0x0000.
- Reset mid-frame: `reset` after 5 pixels.
  - Expect all outputs at reset values on the next cycle and `we`=0.
  - A later `start` writes from 0x0000.
- Default size (256×256): stream 65536 pixels.
  - Check that row 1 starts at 0x0100, the last address is 0xFFFF, and `done` pulses exactly once.
